// File: rtl/resample_interp.sv
// Fractional-rate multi-channel downsampler with zero-order-hold or linear
// interpolation and a four-stage AXI-Stream pipeline.
module resample_interp #(
  parameter int RATE_IN      = 122_880,
  parameter int RATE_OUT     = 20_000,
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAC_BITS    = 12,
  parameter int MODE         = 1
) (
  input  logic                           s00_axis_aclk,
  input  logic                           s00_axis_areset,
  input  logic                           phase_clear,
  input  logic                           s00_axis_tvalid,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] s00_axis_tdata,
  output logic                           s00_axis_tready,
  input  logic                           m00_axis_tready,
  output logic                           m00_axis_tvalid,
  output logic [NUM_CH*SAMPLE_WIDTH-1:0] m00_axis_tdata
);

  localparam int AW  = $clog2(RATE_IN + RATE_OUT) + 1;
  localparam int DW  = NUM_CH * SAMPLE_WIDTH;
  localparam int MW  = FRAC_BITS + 1;
  localparam int RW  = FRAC_BITS + 26;
  localparam int PW  = AW + RW;
  localparam int DFW = SAMPLE_WIDTH + 1;
  localparam int PRW = SAMPLE_WIDTH + FRAC_BITS + 2;
  localparam int MSW = MW + 1;

  localparam logic [RW-1:0] RECIP =
    RW'((64'd1 << (FRAC_BITS + 24)) / 64'(RATE_OUT) + 64'd1);
  localparam logic [AW-1:0] RIN    = AW'(RATE_IN);
  localparam logic [AW-1:0] ROUT   = AW'(RATE_OUT);
  localparam logic [MW-1:0] MU_MAX = MW'(1) << FRAC_BITS;

  logic en;
  logic take;

  assign en              = ~m00_axis_tvalid | m00_axis_tready;
  assign s00_axis_tready = en;
  assign take            = s00_axis_tvalid & en;

  // S0: phase accumulator; a same-cycle clear acts before the beat
  logic [AW-1:0] acc, acc_base, sum, rem;
  logic [DW-1:0] prev, prev_base;
  logic          hit;

  always_comb begin
    acc_base  = phase_clear ? '0 : acc;
    prev_base = phase_clear ? '0 : prev;
    sum       = acc_base + ROUT;
    hit       = (sum >= RIN);
    rem       = hit ? sum - RIN : sum;
  end

  logic          v1;
  logic [AW-1:0] r1;
  logic [DW-1:0] cur1, prev1;

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      acc   <= '0;
      prev  <= '0;
      v1    <= 1'b0;
      r1    <= '0;
      cur1  <= '0;
      prev1 <= '0;
    end else begin
      if (take) begin
        acc  <= rem;
        prev <= s00_axis_tdata;
      end else if (phase_clear) begin
        acc  <= '0;
        prev <= '0;
      end
      if (en) begin
        v1    <= take & hit;
        r1    <= rem;
        cur1  <= s00_axis_tdata;
        prev1 <= prev_base;
      end
    end
  end

  // S1: mu = (RATE_OUT - r) / RATE_OUT via reciprocal multiply
  logic [AW-1:0] num;
  logic [PW-1:0] mu_prod, mu_raw;
  logic [MW-1:0] mu;

  always_comb begin
    num     = ROUT - r1;
    mu_prod = PW'(num) * PW'(RECIP);
    mu_raw  = mu_prod >> 24;
    mu      = (mu_raw > PW'(MU_MAX)) ? MU_MAX : mu_raw[MW-1:0];
  end

  logic          v2;
  logic [MW-1:0] mu2;
  logic [DW-1:0] cur2, prev2;

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      v2    <= 1'b0;
      mu2   <= '0;
      cur2  <= '0;
      prev2 <= '0;
    end else if (en) begin
      v2    <= v1;
      mu2   <= mu;
      cur2  <= cur1;
      prev2 <= prev1;
    end
  end

  // S2: per-channel interpolation, floor shift keeps y between prev and cur
  logic [DW-1:0] ybus;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [SAMPLE_WIDTH-1:0] cs, ps, yi;
    logic signed [DFW-1:0]          diff;
    logic signed [PRW-1:0]          prod;

    assign cs   = cur2[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign ps   = prev2[c*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign diff = DFW'(cs) - DFW'(ps);
    assign prod = PRW'(diff) * PRW'($signed(MSW'(mu2)));
    assign yi   = SAMPLE_WIDTH'(PRW'(ps) + (prod >>> FRAC_BITS));

    assign ybus[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = (MODE == 0) ? cs : yi;
  end

  // S3: output register, frozen while downstream stalls
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
    end else if (en) begin
      m00_axis_tvalid <= v2;
      if (v2) m00_axis_tdata <= ybus;
    end
  end

endmodule

// File: tb/tb_resample_interp.sv
// Bench for resample_interp: a 3/2 linear instance and a 6/1 hold instance
// checked against an arithmetic model of the resampling rules.
module tb_resample_interp;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear   [2];
  logic        s_valid [2];
  logic [31:0] s_data  [2];
  logic        s_ready [2];
  logic        m_ready [2];
  logic        m_valid [2];
  logic [31:0] m_data  [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit bp = 1'b0;
  bit lat_chk = 1'b0;

  int rin_a  [2] = '{3, 6};
  int rout_a [2] = '{2, 1};
  int mode_a [2] = '{1, 0};

  longint m_acc  [2];
  longint m_prev [2][2];
  exp_t   q      [2][$];
  logic [31:0] got [2][$];
  bit          last_stall [2];
  logic [31:0] last_data  [2];

  always #5 clk = ~clk;

  resample_interp #(
    .RATE_IN(3), .RATE_OUT(2), .NUM_CH(2),
    .SAMPLE_WIDTH(16), .FRAC_BITS(12), .MODE(1)
  ) dut_lin (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .phase_clear(clear[0]),
    .s00_axis_tvalid(s_valid[0]), .s00_axis_tdata(s_data[0]),
    .s00_axis_tready(s_ready[0]), .m00_axis_tready(m_ready[0]),
    .m00_axis_tvalid(m_valid[0]), .m00_axis_tdata(m_data[0])
  );

  resample_interp #(
    .RATE_IN(6), .RATE_OUT(1), .NUM_CH(2),
    .SAMPLE_WIDTH(16), .FRAC_BITS(12), .MODE(0)
  ) dut_zoh (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .phase_clear(clear[1]),
    .s00_axis_tvalid(s_valid[1]), .s00_axis_tdata(s_data[1]),
    .s00_axis_tready(s_ready[1]), .m00_axis_tready(m_ready[1]),
    .m00_axis_tvalid(m_valid[1]), .m00_axis_tdata(m_data[1])
  );

  task automatic model_clear(int k);
    m_acc[k] = 0;
    m_prev[k][0] = 0;
    m_prev[k][1] = 0;
  endtask

  // one accepted beat: phase step, optional emission, history update
  task automatic model_beat(int k, logic [31:0] d, bit clr);
    longint s, r, mu, rc, cur, y;
    logic [31:0] o;
    logic [15:0] y16;
    exp_t e;
    if (clr) model_clear(k);
    s = m_acc[k] + rout_a[k];
    o = '0;
    if (s >= rin_a[k]) begin
      r = s - rin_a[k];
      m_acc[k] = r;
      rc = ((longint'(1)) << 36) / rout_a[k] + 1;
      mu = ((rout_a[k] - r) * rc) >>> 24;
      if (mu > 4096) mu = 4096;
      for (int c = 0; c < 2; c++) begin
        cur = longint'($signed(d[c*16 +: 16]));
        if (mode_a[k] == 0) y = cur;
        else y = m_prev[k][c] + (((cur - m_prev[k][c]) * mu) >>> 12);
        y16 = y[15:0];
        o[c*16 +: 16] = y16;
      end
      e.d = o;
      e.cyc = cyc;
      q[k].push_back(e);
    end else begin
      m_acc[k] = s;
    end
    for (int c = 0; c < 2; c++)
      m_prev[k][c] = longint'($signed(d[c*16 +: 16]));
  endtask

  // single compare/monitor process, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_clear(k);
        q[k].delete();
        last_stall[k] = 1'b0;
      end else begin
        if (last_stall[k]) begin
          checks++;
          if (!(m_valid[k] && m_data[k] == last_data[k])) begin
            failures++;
            $display("FAIL stall_hold k=%0d valid=%b data=%h required=%h",
                     k, m_valid[k], m_data[k], last_data[k]);
          end
        end
        last_stall[k] = m_valid[k] && !m_ready[k];
        last_data[k] = m_data[k];
        if (m_valid[k] && m_ready[k]) begin
          got[k].push_back(m_data[k]);
          checks++;
          if (q[k].size() == 0) begin
            failures++;
            $display("FAIL unexpected_out k=%0d data=%h required=none",
                     k, m_data[k]);
          end else begin
            e = q[k].pop_front();
            if (m_data[k] !== e.d) begin
              failures++;
              $display("FAIL out_data k=%0d got=%h required=%h",
                       k, m_data[k], e.d);
            end
            if (lat_chk && (cyc != e.cyc + 3)) begin
              failures++;
              $display("FAIL latency k=%0d got=%0d required=3",
                       k, cyc - e.cyc);
            end
          end
        end
        if (s_valid[k] && s_ready[k]) model_beat(k, s_data[k], clear[k]);
        else if (clear[k]) model_clear(k);
      end
    end
  end

  initial begin
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++)
        m_ready[k] = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic send(int k, logic [31:0] d, bit clr);
    int n = 0;
    bit ok = 1'b0;
    s_data[k] = d;
    s_valid[k] = 1'b1;
    clear[k] = clr;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = s_ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout k=%0d waited=%0d required<1000", k, n);
    end
    s_valid[k] = 1'b0;
    clear[k] = 1'b0;
  endtask

  task automatic rand_run(int k, int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        s_valid[k] = 1'b0;
        @(posedge clk);
        #1;
      end
      send(k, $urandom, $urandom_range(0, 49) == 0);
    end
  endtask

  task automatic lin_directed();
    send(0, {16'd0, 16'd100}, 1'b0);
    send(0, {16'd0, 16'd201}, 1'b0);
    send(0, {16'd0, 16'd300}, 1'b0);
    send(0, {16'd0, 16'd400}, 1'b0);
    send(0, {16'd0, 16'd501}, 1'b0);
    send(0, {16'h0000, 16'hFF9C}, 1'b1);
    send(0, {16'h7FFF, 16'hFF37}, 1'b0);
  endtask

  task automatic zoh_directed();
    for (int i = 0; i < 24; i++) send(1, {16'(-i), 16'(i)}, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++;
      $display("FAIL drain_timeout left0=%0d left1=%0d required=0",
               q[0].size(), q[1].size());
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_list(int k, logic [31:0] ref_v [4], string name);
    checks++;
    if (got[k].size() != 4) begin
      failures++;
      $display("FAIL %s_count got=%0d required=4", name, got[k].size());
    end
    for (int i = 0; i < 4 && i < got[k].size(); i++) begin
      checks++;
      if (got[k][i] !== ref_v[i]) begin
        failures++;
        $display("FAIL %s[%0d] got=%h required=%h",
                 name, i, got[k][i], ref_v[i]);
      end
    end
  endtask

  task automatic check_reset_state(string name);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_valid[k] !== 1'b0 || m_data[k] !== 32'd0 || s_ready[k] !== 1'b1) begin
        failures++;
        $display("FAIL %s k=%0d valid=%b data=%h ready=%b required=0/0/1",
                 name, k, m_valid[k], m_data[k], s_ready[k]);
      end
    end
  endtask

  logic [31:0] lin_ref [4] = '{32'h0000_0096, 32'h0000_012C,
                               32'h0000_01C2, 32'h3FFF_FF69};
  logic [31:0] zoh_ref [4] = '{32'hFFFB_0005, 32'hFFF5_000B,
                               32'hFFEF_0011, 32'hFFE9_0017};

  initial begin
    for (int k = 0; k < 2; k++) begin
      clear[k] = 1'b0;
      s_valid[k] = 1'b0;
      s_data[k] = '0;
      model_clear(k);
      last_stall[k] = 1'b0;
      last_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;

    lat_chk = 1'b1;
    got[0].delete();
    got[1].delete();
    fork
      lin_directed();
      zoh_directed();
    join
    drain();
    lat_chk = 1'b0;
    check_list(0, lin_ref, "lin_directed");
    check_list(1, zoh_ref, "zoh_directed");

    bp = 1'b1;
    fork
      rand_run(0, 1500);
      rand_run(1, 900);
    join
    bp = 1'b0;
    drain();

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        s_valid[k] = 1'b1;
        s_data[k] = $urandom;
      end
      @(posedge clk);
      #1;
    end
    s_valid[0] = 1'b0;
    s_valid[1] = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_state("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    lat_chk = 1'b1;
    got[0].delete();
    lin_directed();
    drain();
    lat_chk = 1'b0;
    check_list(0, lin_ref, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resample_interp.md
# resample_interp

Parametrised fractional-rate downsampler for multi-channel packed sample streams, RATE_IN → RATE_OUT, with selectable zero-order-hold or linear interpolation and full AXI-Stream backpressure. Sits between the front-end FIR and the CSI extractor. It generalises the existing zero-order-hold path to N channels, programmable sample width and a fractional-phase interpolator.

## Interface
- RATE_IN, 122_880: input rate (arbitrary units, same as RATE_OUT).
- RATE_OUT, 20_000: output rate. Legal range is 1 ≤ RATE_OUT < RATE_IN.
- NUM_CH, 2: channels packed per beat.
- SAMPLE_WIDTH, 16: signed sample width per channel.
- FRAC_BITS, 12: interpolation weight precision.
- MODE, 1: 0 = zero-order hold, 1 = linear interpolation.
- s00_axis_aclk  in  1  sole clock.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- phase_clear  in  1  synchronous clear of phase accumulator and history.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tdata  in  NUM_CH*SAMPLE_WIDTH  channel c occupies bits [c*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- s00_axis_tready  out  1  input accepted when high with tvalid.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  output beat valid.
- m00_axis_tdata  out  NUM_CH*SAMPLE_WIDTH  same packing as input.

## Operation
- Phase accumulator `acc`:
  - Width $clog2(RATE_IN+RATE_OUT)+1; range [0, RATE_IN).
  - On each accepted beat, `s = acc + RATE_OUT`.
  - If s ≥ RATE_IN: emit one output, r = s − RATE_IN, acc ← r.
  - Otherwise acc ← s, and the beat only updates history.
- History `prev`: per-channel register holding the previous accepted sample. It updates on every accepted beat, whether or not an output is emitted.
- Weight on the current sample: mu = min(((RATE_OUT − r) * RECIP) >> 24, 2^FRAC_BITS), where RECIP = floor(2^(FRAC_BITS+24)/RATE_OUT)+1 is a localparam. No runtime divider.
- MODE 0 output: the current sample, per channel.
- MODE 1 output, per channel:
  - y = prev + (((cur − prev) * mu) >>> FRAC_BITS).
  - diff is SAMPLE_WIDTH+1 signed; the product is SAMPLE_WIDTH+FRAC_BITS+2 signed; the shift is arithmetic (floor).
  - y always lies between prev and cur, so no saturation is needed.
- Channels share acc and mu and are interpolated independently.
- The first beat after reset or clear never emits (RATE_OUT < RATE_IN), so the reset value prev = 0 is never interpolated against.
- phase_clear sets acc ← 0 and prev ← 0.
  - If it coincides with an accepted beat, the clear applies first and that beat is then processed as the first beat after clear: acc ← RATE_OUT, prev ← beat.
  - Beats already in the pipeline still complete and are delivered.

## Timing
- Pipeline stages:
  - S0: accept, acc update, r.
  - S1: mu multiply.
  - S2: interpolation multiply.
  - S3: output register.
- Each stage carries a valid bit, and only emitting beats carry valid.
- Global advance enable: en = ~m00_axis_tvalid | m00_axis_tready.
  - s00_axis_tready = en. This is combinational from m00_axis_tready and is intentional.
  - All stages hold when en = 0.
- Latency: an emitting beat accepted at cycle t appears with m00_axis_tvalid = 1 at cycle t+3, provided en stays high.
- m00_axis_tvalid/tdata stay stable while tvalid=1 and tready=0. tvalid drops the cycle after a handshake when no new result arrives.
- Throughput: 1 input beat/cycle with no backpressure. No beat is lost or duplicated under any tready pattern.
- Reset values (asynchronous, immediate):
  - m00_axis_tvalid = 0, m00_axis_tdata = 0.
  - acc = 0, prev = 0, all stage valids = 0.
  - s00_axis_tready = 1.
- Reset mid-stream discards all in-flight beats. No output is produced for them.

## Test plan
- Linear mode, RATE_IN=3, RATE_OUT=2, NUM_CH=1, inputs 100, 201, 300, 400, 501:
  - Outputs 150 (mu=2048), then 300 (mu=4096), then 450.
  - Exactly 3 outputs; each appears 3 cycles after its triggering beat.
- Negative and channel independence, NUM_CH=2, same rates:
  - ch0 inputs −100, −201 → −151 (floor).
  - ch1 inputs 0, 32767 → 16383.
  - Packing is preserved.
- MODE=0, RATE_IN=6, RATE_OUT=1, ramp 0..23 → outputs 5, 11, 17, 23. Count is exactly 1 per 6 beats.
- Backpressure: random m00_axis_tready at 30% duty with continuous tvalid.
  - The output sequence matches the no-backpressure golden model bit-exactly.
  - tdata is stable while stalled.
- phase_clear asserted with an accepted beat mid-stream (RATE 3/2):
  - The next output occurs on the 2nd beat after clear.
  - It interpolates from the clear-cycle beat, not from pre-clear history.
- Async reset pulse while 3 beats are in flight:
  - tvalid falls immediately and no stale beats emerge.
  - The post-reset sequence matches a fresh start.
